// File: rtl/ocra1_pkg.sv
// Shared OCRA1 constants: channel indices, DAC word field positions and default payloads.
package ocra1_pkg;

   localparam logic [1:0] CH_X  = 2'd0;
   localparam logic [1:0] CH_Y  = 2'd1;
   localparam logic [1:0] CH_Z  = 2'd2;
   localparam logic [1:0] CH_Z2 = 2'd3;

   localparam int UPD_BIT = 24;
   localparam int CH_LSB  = 25;
   localparam int CH_MSB  = 26;

   localparam logic [3:0]  VOLT_PREFIX       = 4'h1;
   localparam logic [23:0] INIT_WORD_DEFAULT = 24'h200002;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BURST,
      ST_HOLD
   } stager_state_e;

endpackage

// File: rtl/ocra1_grad_stager.sv
// Stages four gradient channel values and issues them as 4-word bursts to ocra1_iface,
// with a DAC init burst after reset and on request.
module ocra1_grad_stager
   import ocra1_pkg::*;
#(
   parameter logic [23:0] INIT_WORD   = INIT_WORD_DEFAULT,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [17:0] ch_data_i,
   input  logic [1:0]  ch_addr_i,
   input  logic        ch_we_i,
   input  logic        commit_i,
   input  logic        init_i,
   input  logic        busy_i,
   output logic [31:0] data_o,
   output logic        valid_o,
   output logic        pending_o,
   output logic        overrun_o
);

   localparam logic [2:0] HOLD_LAST = 3'(HOLD_CYCLES - 1);

   stager_state_e     state_q;
   logic [1:0]        cnt_q;
   logic [2:0]        hold_q;
   logic              init_burst_q;
   logic              init_pend_q, init_pend_d;
   logic              commit_pend_q, commit_pend_d;
   logic              overrun_q, overrun_d;
   logic signed [17:0] stage_q [4];
   logic signed [17:0] stage_d [4];
   logic signed [17:0] snap_q  [4];
   logic [31:0]       data_q;
   logic              valid_q;

   logic              req_init, req_commit;
   logic              start, start_init, start_commit;
   logic [1:0]        cnt_nxt;
   logic [23:0]       burst_payload;

   function automatic logic [23:0] volt_payload(input logic signed [17:0] v);
      return {VOLT_PREFIX, v, 2'b00};
   endfunction

   function automatic logic [31:0] mk_word(input logic [1:0] ch, input logic [23:0] payload);
      logic [31:0] w;
      w                = '0;
      w[CH_MSB:CH_LSB] = ch;
      w[UPD_BIT]       = (ch == CH_Z2);
      w[23:0]          = payload;
      return w;
   endfunction

   always_comb begin
      stage_d = stage_q;
      if (ch_we_i) stage_d[ch_addr_i] = signed'(ch_data_i);

      // A request arriving this cycle can launch a burst at this very edge.
      req_init     = init_pend_q | init_i;
      req_commit   = commit_pend_q | commit_i;
      start        = (state_q == ST_IDLE) & (req_init | req_commit) & ~busy_i;
      start_init   = start & req_init;
      start_commit = start & ~req_init;

      init_pend_d   = req_init & ~start_init;
      commit_pend_d = req_commit & ~start_commit;
      overrun_d     = overrun_q | (commit_i & commit_pend_q);

      cnt_nxt       = cnt_q + 2'd1;
      burst_payload = init_burst_q ? INIT_WORD : volt_payload(snap_q[cnt_nxt]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 2'd0;
         hold_q        <= 3'd0;
         init_burst_q  <= 1'b0;
         init_pend_q   <= 1'b1;
         commit_pend_q <= 1'b0;
         overrun_q     <= 1'b0;
         stage_q       <= '{default: '0};
         snap_q        <= '{default: '0};
         data_q        <= '0;
         valid_q       <= 1'b0;
      end else begin
         stage_q       <= stage_d;
         init_pend_q   <= init_pend_d;
         commit_pend_q <= commit_pend_d;
         overrun_q     <= overrun_d;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q      <= ST_BURST;
                  cnt_q        <= 2'd0;
                  valid_q      <= 1'b1;
                  init_burst_q <= start_init;
                  data_q       <= start_init ? mk_word(CH_X, INIT_WORD)
                                             : mk_word(CH_X, volt_payload(stage_d[0]));
                  if (start_commit) snap_q <= stage_d;
               end
            end
            ST_BURST: begin
               if (cnt_q == 2'd3) begin
                  valid_q <= 1'b0;
                  hold_q  <= 3'd1;
                  state_q <= (HOLD_CYCLES > 1) ? ST_HOLD : ST_IDLE;
               end else begin
                  cnt_q  <= cnt_nxt;
                  data_q <= mk_word(cnt_nxt, burst_payload);
               end
            end
            ST_HOLD: begin
               // The IDLE decision cycle is the final guard cycle, so HOLD itself is one shorter.
               if (hold_q >= HOLD_LAST) state_q <= ST_IDLE;
               else                     hold_q  <= hold_q + 3'd1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign pending_o = init_pend_q | commit_pend_q;
   assign overrun_o = overrun_q;

endmodule

// File: tb/tb_ocra1_grad_stager.sv
// Randomised and directed bench for ocra1_grad_stager against a queue-based burst model.
module tb_ocra1_grad_stager;

   localparam logic [23:0] INIT_W = 24'h200002;
   localparam int          HOLD   = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [17:0] ch_data_i;
   logic [1:0]  ch_addr_i;
   logic        ch_we_i, commit_i, init_i, busy_i;
   logic [31:0] data_o;
   logic        valid_o, pending_o, overrun_o;

   always #5 clk = ~clk;

   ocra1_grad_stager #(.INIT_WORD(INIT_W), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .ch_data_i(ch_data_i), .ch_addr_i(ch_addr_i),
      .ch_we_i(ch_we_i), .commit_i(commit_i), .init_i(init_i), .busy_i(busy_i),
      .data_o(data_o), .valid_o(valid_o), .pending_o(pending_o), .overrun_o(overrun_o)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: requests, staging and a queue of words waiting to go out.
   logic [17:0] m_stage [4];
   logic [31:0] m_q [$];
   bit          m_ipend, m_cpend, m_ovr, m_valid;
   logic [31:0] m_data;
   int          m_low;

   function automatic logic [31:0] mkw(input int c, input logic [23:0] p);
      logic [1:0] ch;
      ch = 2'(c);
      return {5'd0, ch, (c == 3), p};
   endfunction

   task automatic model_step();
      bit ri, rc;
      if (!rst_n) begin
         m_q.delete();
         for (int i = 0; i < 4; i++) m_stage[i] = '0;
         m_ipend = 1; m_cpend = 0; m_ovr = 0;
         m_data = '0; m_valid = 0; m_low = HOLD;
         return;
      end
      ri = m_ipend | init_i;
      rc = m_cpend | commit_i;
      if (commit_i && m_cpend) m_ovr = 1;
      if (ch_we_i) m_stage[ch_addr_i] = ch_data_i;
      // A new burst may start only once the output has been quiet for HOLD cycles.
      if (m_q.size() == 0 && m_low >= HOLD && (ri || rc) && !busy_i) begin
         if (ri) begin
            for (int c = 0; c < 4; c++) m_q.push_back(mkw(c, INIT_W));
            ri = 0;
         end else begin
            for (int c = 0; c < 4; c++) m_q.push_back(mkw(c, {4'h1, m_stage[c], 2'b00}));
            rc = 0;
         end
      end
      m_ipend = ri;
      m_cpend = rc;
      if (m_q.size() > 0) begin
         m_data = m_q.pop_front(); m_valid = 1; m_low = 0;
      end else begin
         m_valid = 0;
         if (m_low < HOLD) m_low++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk_val("valid", {31'd0, valid_o}, {31'd0, m_valid});
      chk_val("data", data_o, m_data);
      chk_val("pending", {31'd0, pending_o}, {31'd0, m_ipend | m_cpend});
      chk_val("overrun", {31'd0, overrun_o}, {31'd0, m_ovr});
   endtask

   task automatic expect_burst(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
      int k = 0;
      while (!valid_o && k < 100) begin tick(); k++; end
      if (!valid_o) begin
         chk_val({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      chk_val({tag, "_w0"}, data_o, w0); tick();
      chk_val({tag, "_w1"}, data_o, w1); tick();
      chk_val({tag, "_w2"}, data_o, w2); tick();
      chk_val({tag, "_w3"}, data_o, w3);
   endtask

   task automatic idle_inputs();
      ch_we_i = 0; commit_i = 0; init_i = 0; ch_addr_i = '0; ch_data_i = '0;
   endtask

   initial begin
      int cnt;
      rst_n = 0; busy_i = 0;
      idle_inputs();

      // Post-reset init burst
      repeat (3) tick();
      chk_val("rst_pending", {31'd0, pending_o}, 32'd1);
      chk_val("rst_data", data_o, 32'd0);
      rst_n = 1;
      expect_burst("init", 32'h00200002, 32'h02200002, 32'h04200002, 32'h07200002);
      repeat (3) tick();
      chk_val("init_pending", {31'd0, pending_o}, 32'd0);

      // Voltage burst of 1..4
      for (int i = 0; i < 4; i++) begin
         ch_we_i = 1; ch_addr_i = 2'(i); ch_data_i = 18'(i + 1); tick();
      end
      idle_inputs();
      commit_i = 1; tick(); commit_i = 0;
      expect_burst("volt", 32'h00100004, 32'h02100008, 32'h0410000C, 32'h07100010);

      // Busy gating
      busy_i = 1;
      commit_i = 1; tick(); commit_i = 0;
      repeat (50) tick();
      chk_val("busy_pending", {31'd0, pending_o}, 32'd1);
      busy_i = 0; tick();
      chk_val("busy_release", {31'd0, valid_o}, 32'd1);
      repeat (8) tick();

      // Snapshot isolation
      ch_we_i = 1; ch_addr_i = 2'd0; ch_data_i = 18'd5; tick();
      idle_inputs();
      commit_i = 1; tick(); commit_i = 0;
      chk_val("snap_x5", data_o, 32'h00100014);
      ch_we_i = 1; ch_addr_i = 2'd0; ch_data_i = 18'h3FFFF; tick();
      idle_inputs();
      repeat (6) tick();
      commit_i = 1; tick(); commit_i = 0;
      chk_val("snap_xm1", data_o, 32'h001FFFFC);
      repeat (8) tick();

      // Overrun: two commits while busy yield one burst
      busy_i = 1;
      commit_i = 1; tick(); commit_i = 0; tick();
      commit_i = 1; tick(); commit_i = 0;
      repeat (5) tick();
      chk_val("ovr_set", {31'd0, overrun_o}, 32'd1);
      busy_i = 0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (valid_o) cnt++; end
      chk_val("ovr_one_burst", 32'(cnt), 32'd4);
      chk_val("ovr_sticky", {31'd0, overrun_o}, 32'd1);

      // Reset mid-burst
      commit_i = 1; tick(); commit_i = 0;
      tick(); tick();
      rst_n = 0; tick();
      chk_val("midrst_valid", {31'd0, valid_o}, 32'd0);
      chk_val("midrst_ovr", {31'd0, overrun_o}, 32'd0);
      rst_n = 1;
      expect_burst("reinit", 32'h00200002, 32'h02200002, 32'h04200002, 32'h07200002);
      repeat (4) tick();

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         ch_we_i   = ($urandom_range(0, 2) == 0);
         ch_addr_i = 2'($urandom_range(0, 3));
         ch_data_i = 18'($urandom);
         commit_i  = ($urandom_range(0, 7) == 0);
         init_i    = ($urandom_range(0, 29) == 0);
         busy_i    = ($urandom_range(0, 3) == 0);
         rst_n     = ($urandom_range(0, 199) != 0);
         tick();
      end
      rst_n = 1; busy_i = 0;
      idle_inputs();
      repeat (20) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
